// File: rtl/adder_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// add_arb_pkg
//   Shared definitions for the adder-sharing arbiter slice: default widths,
//   a helper that sizes requester-id fields, and the requester id type used
//   at the default requester count.
// ---------------------------------------------------------------------------
package add_arb_pkg;

  // Operand/result width is tied to the shared 8-bit adder.
  localparam int DATA_W_DEF  = 8;
  localparam int NUM_REQ_DEF = 4;

  // Width of an id field able to name n requesters; never narrower than 1 bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/adder_share_arbiter_rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
//   Combinational round-robin priority picker. Chooses the first asserted
//   request at or after the pointer, wrapping around to index 0.
//   Ports:
//     req_i        in  N   request vector
//     ptr_i        in  IW  highest-priority index this cycle
//     grant_o      out N   one-hot grant (zero when no request)
//     grant_idx_o  out IW  index of the granted request
//     any_grant_o  out 1   at least one request is asserted
// ---------------------------------------------------------------------------
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_grant_o
);

  logic          hi_any;
  logic [IW-1:0] hi_idx;
  logic          lo_any;
  logic [IW-1:0] lo_idx;

  // Scan downwards so the last hit is the lowest index. lo_* tracks the
  // lowest request overall (the wrap-around choice); hi_* tracks the lowest
  // request at or above the pointer, which wins whenever it exists.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_any = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(ptr_i)) begin
          hi_any = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    any_grant_o = lo_any;
    grant_idx_o = hi_any ? hi_idx : lo_idx;
    grant_o     = '0;
    if (lo_any) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/eight_bit_half_adder.sv
// ---------------------------------------------------------------------------
// eight_bit_half_adder
//   The team's shared 8-bit adder: out = (a + b) mod 256, no carry out.
//   Ports:
//     a   in  8  operand A
//     b   in  8  operand B
//     out out 8  modulo-256 sum
// ---------------------------------------------------------------------------
module eight_bit_half_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out
);

  assign out = a + b;

endmodule

// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//   Shares one 8-bit adder between NUM_REQ valid/ready requesters, served
//   round-robin. Each result lands in a single registered output slot tagged
//   with the requester id and an overflow flag; 1-cycle latency and full
//   throughput while the consumer keeps rsp_ready high.
//
//   Build option: define ADD_SAT_EN to clamp overflowing sums to 255
//   (rsp_ovf still reports the overflow). Default build wraps modulo 256.
//
//   Ports:
//     clk        in  1                rising-edge clock
//     rst_n      in  1                asynchronous active-low reset
//     req_valid  in  NUM_REQ          per-requester operand valid
//     req_ready  out NUM_REQ          per-requester accept, one-hot or zero
//     req_a      in  NUM_REQ*DATA_W   packed operand A, lane i at [i*DATA_W +: DATA_W]
//     req_b      in  NUM_REQ*DATA_W   packed operand B, same packing
//     rsp_valid  out 1                result slot holds a valid result
//     rsp_ready  in  1                consumer accepts the result
//     rsp_sum    out DATA_W           registered sum
//     rsp_id     out ID_W             requester that produced rsp_sum
//     rsp_ovf    out 1                true a+b did not fit in DATA_W bits
// ---------------------------------------------------------------------------
module adder_share_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_ovf
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               accept;
  logic               xfer;

  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic [DATA_W-1:0]  sum_raw;
  logic [DATA_W-1:0]  sum_res;
  logic               ovf_res;

  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_sum_q,   rsp_sum_d;
  logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
  logic               rsp_ovf_q,   rsp_ovf_d;
  logic [ID_W-1:0]    ptr_q,       ptr_d;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_grant (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // The slot can take a new result when it is empty or is draining now.
  assign accept    = !rsp_valid_q || rsp_ready;
  assign req_ready = accept ? grant : '0;
  assign xfer      = accept && any_grant;

  // Steer the granted lane's operands into the single shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*DATA_W +: DATA_W];
        b_sel = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  eight_bit_half_adder u_adder (
    .a   (a_sel),
    .b   (b_sel),
    .out (sum_raw)
  );

  // A modulo sum smaller than an operand means the addition wrapped.
  always_comb begin
    ovf_res = (sum_raw < a_sel);
`ifdef ADD_SAT_EN
    sum_res = ovf_res ? '1 : sum_raw;
`else
    sum_res = sum_raw;
`endif
  end

  // Slot and pointer next state. A transfer refills the slot (even while it
  // drains, so there is no bubble) and moves the pointer past the winner;
  // a drain without a transfer only clears valid, leaving the data fields.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum_res;
      rsp_id_d    = grant_idx;
      rsp_ovf_d   = ovf_res;
      ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arbiter
//   Directed bench for adder_share_arbiter at NUM_REQ=4, DATA_W=8. Inputs
//   change 1 time unit after each rising edge and outputs are sampled there
//   too, well away from the active edge. Build with ADD_SAT_EN defined to
//   check the saturating variant.
// ---------------------------------------------------------------------------
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;

  int tests;
  int fails;

  // Fixed per-lane operands for the multi-requester scenarios, with the
  // hand-computed results: lane0 250+10=260, lane1 17+33=50,
  // lane2 128+128=256, lane3 60+195=255 (largest sum that does not overflow).
  logic [7:0] lane_a   [4];
  logic [7:0] lane_b   [4];
  logic [7:0] lane_sum [4];
  logic       lane_ovf [4];

  adder_share_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load every lane with its table operands.
  task automatic load_lanes();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = lane_a[i];
      req_b[i*8 +: 8] = lane_b[i];
    end
  endtask

  // Brief reset pulse placed between edges, then settle to the next cycle.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Outputs are zero straight out of reset.
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #3;
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", rsp_valid); end
    tests++;
    if (rsp_sum !== 8'd0) begin fails++; $display("[TB] FAIL reset_sum: got %0d want 0", rsp_sum); end
    tests++;
    if (rsp_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_id: got %0d want 0", rsp_id); end
    tests++;
    if (rsp_ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b want 0", rsp_ovf); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Lone requester 2 with an overflowing pair, then a drain with no new work.
  task automatic test_single();
    logic [7:0] want_sum;
`ifdef ADD_SAT_EN
    want_sum = 8'd255;
`else
    want_sum = 8'd44;
`endif
    req_a[2*8 +: 8] = 8'd200;
    req_b[2*8 +: 8] = 8'd100;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL single_ready: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== want_sum || rsp_ovf !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_rsp: got v=%b id=%0d sum=%0d ovf=%b want v=1 id=2 sum=%0d ovf=1",
               rsp_valid, rsp_id, rsp_sum, rsp_ovf, want_sum);
    end
    next_cycle();
    tests++;
    if (rsp_valid !== 1'b0 || rsp_sum !== want_sum) begin
      fails++;
      $display("[TB] FAIL single_drain: got v=%b sum=%0d want v=0 sum=%0d", rsp_valid, rsp_sum, want_sum);
    end
  endtask

  // All four requesters valid from reset: ids 0,1,2,3,0,1 with no gaps.
  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    pulse_reset();
    load_lanes();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      tests++;
      if (req_ready !== (4'b0001 << seq[k])) begin
        fails++;
        $display("[TB] FAIL rr_ready[%0d]: got %b want one-hot %0d", k, req_ready, seq[k]);
      end
      next_cycle();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(seq[k]) || rsp_sum !== lane_sum[seq[k]] || rsp_ovf !== lane_ovf[seq[k]]) begin
        fails++;
        $display("[TB] FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%0d ovf=%b want v=1 id=%0d sum=%0d ovf=%b",
                 k, rsp_valid, rsp_id, rsp_sum, rsp_ovf, seq[k], lane_sum[seq[k]], lane_ovf[seq[k]]);
      end
    end
    req_valid = 4'b0000;
  endtask

  // Pointer sits at 2 after the previous run. Requesters 1 and 3 alternate
  // 3,1,3,1; raising requester 0 then gives 3,0,1.
  task automatic test_fairness();
    int seq [7] = '{3, 1, 3, 1, 3, 0, 1};
    next_cycle();
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4) ? 4'b1010 : 4'b1011;
      next_cycle();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(seq[k]) || rsp_sum !== lane_sum[seq[k]]) begin
        fails++;
        $display("[TB] FAIL fair_rsp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                 k, rsp_valid, rsp_id, rsp_sum, seq[k], lane_sum[seq[k]]);
      end
    end
    req_valid = 4'b0000;
    next_cycle();
  endtask

  // Pointer is 2: grant 2, hold it for 3 stalled cycles, then release and
  // see requester 3 accepted in the same cycle.
  task automatic test_backpressure();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
      next_cycle();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== lane_sum[2] || rsp_ovf !== lane_ovf[2]) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d ovf=%b want v=1 id=2 sum=%0d ovf=%b",
                 k, rsp_valid, rsp_id, rsp_sum, rsp_ovf, lane_sum[2], lane_ovf[2]);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin fails++; $display("[TB] FAIL bp_release_ready: got %b want 1000", req_ready); end
    next_cycle();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== lane_sum[3] || rsp_ovf !== lane_ovf[3]) begin
      fails++;
      $display("[TB] FAIL bp_release_rsp: got v=%b id=%0d sum=%0d ovf=%b want v=1 id=3 sum=%0d ovf=%b",
               rsp_valid, rsp_id, rsp_sum, rsp_ovf, lane_sum[3], lane_ovf[3]);
    end
  endtask

  // Reset lands mid-cycle while a result is held; outputs clear before the
  // next edge and the first grant afterwards goes to requester 0.
  task automatic test_async_reset();
    rsp_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got v=%b sum=%0d id=%0d ovf=%b want all 0", rsp_valid, rsp_sum, rsp_id, rsp_ovf);
    end
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL post_reset_ready: got %b want 0001", req_ready); end
    next_cycle();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== lane_sum[0]) begin
      fails++;
      $display("[TB] FAIL post_reset_rsp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=%0d", rsp_valid, rsp_id, rsp_sum, lane_sum[0]);
    end
    req_valid = 4'b0000;
    next_cycle();
  endtask

  // Requester 1 streams every operand pair; the other lanes carry junk
  // so a wrong operand mux shows up in the results.
  task automatic test_sweep();
    int s;
    logic [7:0] want_sum;
    logic       want_ovf;
    req_a     = {4{8'hAA}};
    req_b     = {4{8'h55}};
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        req_a[1*8 +: 8] = 8'(a);
        req_b[1*8 +: 8] = 8'(b);
        next_cycle();
        s        = a + b;
        want_ovf = (s > 255);
`ifdef ADD_SAT_EN
        want_sum = want_ovf ? 8'd255 : 8'(s);
`else
        want_sum = 8'(s % 256);
`endif
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== want_sum || rsp_ovf !== want_ovf) begin
          fails++;
          $display("[TB] FAIL sweep a=%0d b=%0d: got v=%b id=%0d sum=%0d ovf=%b want v=1 id=1 sum=%0d ovf=%b",
                   a, b, rsp_valid, rsp_id, rsp_sum, rsp_ovf, want_sum, want_ovf);
        end
      end
    end
    req_valid = 4'b0000;
    next_cycle();
  endtask

  // Scenario sequence; each task leaves the DUT in the state the next expects.
  initial begin
    tests = 0;
    fails = 0;
    lane_a   = '{8'd250, 8'd17, 8'd128, 8'd60};
    lane_b   = '{8'd10,  8'd33, 8'd128, 8'd195};
`ifdef ADD_SAT_EN
    lane_sum = '{8'd255, 8'd50, 8'd255, 8'd255};
`else
    lane_sum = '{8'd4,   8'd50, 8'd0,   8'd255};
`endif
    lane_ovf = '{1'b1, 1'b0, 1'b1, 1'b0};

    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
